pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 PIPE processor. Each cycle it derives the stall and bubble controls for the F, D, E, M and W pipeline registers and the condition-code write enable from the stage icodes, register IDs and status codes. It also runs a registered run/halt state machine that freezes the pipeline once a non-AOK status retires. Optional performance counters can be compiled in. It sits beside the pipeline registers and drives their stall and bubble inputs directly.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `D_icode`, `E_icode`, `M_icode`  in  4 each  icodes in D, E and M.
- `d_srcA`, `d_srcB`  in  4 each  source registers decoded in D (`4'hF` means none).
- `E_dstM`  in  4  load destination register in E.
- `e_Cnd`  in  1  branch condition computed in E.
- `m_stat`, `W_stat`  in  2 each  status codes; AOK=0, HLT=1, ADR=2, INS=3.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each  pipeline register controls.
- `set_cc`  out  1  condition-code write enable.
- `halted`  out  1  high while the FSM is in HALTED.
- `halt_stat`  out  2  latched status that caused the halt.
- `cyc_cnt`, `stall_cnt`, `bub_cnt`  out  `CNT_W` each  performance counters.

## Operation
- Icode constants: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B.
- `lu` (load/use) = `E_icode` ∈ {MRMOVQ, POPQ} and `E_dstM` ≠ F and `E_dstM` ∈ {`d_srcA`, `d_srcB`}.
- `ret` = RET ∈ {`D_icode`, `E_icode`, `M_icode`}.
- `mp` (mispredict) = `E_icode`==JXX and `e_Cnd`==0.
- `exc` = `m_stat`≠AOK or `W_stat`≠AOK.
- Control equations in RUN:
  - `F_stall` = `lu`|`ret`.
  - `D_stall` = `lu`.
  - `D_bubble` = `mp` | (`ret` & ~`lu`).
  - `E_bubble` = `mp`|`lu`.
  - `M_bubble` = `exc`.
  - `W_stall` = (`W_stat`≠AOK).
  - `set_cc` = (`E_icode`==OPQ) & ~`exc`.
- A stall has priority over a bubble on the same register: with `lu` and `ret` both true, `D_stall`=1 and `D_bubble`=0.
- FSM states are RUN and HALTED.
  - RUN → HALTED at the edge where `W_stat`≠AOK; `halt_stat` captures `W_stat` at that edge.
  - HALTED is left only through `reset`.
- In HALTED, all inputs are ignored:
  - `F_stall`=`D_stall`=`W_stall`=1.
  - `E_bubble`=`M_bubble`=1.
  - `D_bubble`=0 and `set_cc`=0.
  - `halted`=1.
- While `reset` is high, outputs are forced: `D_bubble`=`E_bubble`=`M_bubble`=1, and all stalls, `set_cc` and `halted` are 0. This flushes the pipeline.

## Timing
- Control outputs are combinational from the current inputs and the registered state. The pipeline registers act on them at the same rising edge.
- `halted` and `halt_stat` are registered. `halted` rises one cycle after `W_stat` first goes non-AOK; in that first cycle the combinational `W_stall`=1 already holds W.
- Reset values: state=RUN, `halted`=0, `halt_stat`=0, all counters 0.
- Asserting `reset` in any state, including mid-halt, returns the FSM to RUN at the next edge.

## Configuration
- `PIPE_PERF_EN` defined:
  - `cyc_cnt` increments every non-reset cycle in RUN.
  - `stall_cnt` increments in RUN cycles with `F_stall`=1.
  - `bub_cnt` increments in RUN cycles with `D_bubble`|`E_bubble`.
  - All counters saturate at 2^`CNT_W`−1, freeze in HALTED and clear on `reset`.
- `PIPE_PERF_EN` undefined: no counter flops exist and all three counters are driven constant 0.

## Test plan
- Load/use: `E_icode`=5, `E_dstM`=3, `d_srcA`=3 → `F_stall`=1, `D_stall`=1, `E_bubble`=1, `D_bubble`=0; with `E_dstM`=F instead → all controls 0.
- Ret: `D_icode`=9 for one cycle, then `E_icode`=9, then `M_icode`=9 → three cycles of `F_stall`=1, `D_bubble`=1.
- Mispredict: `E_icode`=7, `e_Cnd`=0 → `D_bubble`=1, `E_bubble`=1, `F_stall`=0; with `D_icode`=9 added → `F_stall`=1 as well.
- Load/use plus ret: `E_icode`=B, `E_dstM`=`d_srcB`=4, `D_icode`=9 → `D_stall`=1, `D_bubble`=0, `E_bubble`=1, `F_stall`=1.
- Halt: `m_stat`=2 → `M_bubble`=1, `set_cc`=0 with `E_icode`=6. Then `W_stat`=2 → `W_stall`=1 that cycle; next cycle `halted`=1, `halt_stat`=2, all stalls 1 regardless of inputs. `reset` one cycle → `halted`=0, state RUN.
- Counters (with `PIPE_PERF_EN`, `CNT_W`=4): 20 RUN cycles with constant `lu` → `cyc_cnt`=15, `stall_cnt`=15 (saturated), `bub_cnt`=15; `reset` → all 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble and condition-code control for the five-stage
// Y86-64 PIPE processor, plus a registered RUN/HALTED state machine.
//
// Build option: define PIPE_PERF_EN to compile in the saturating
// performance counters (cyc_cnt, stall_cnt, bub_cnt). Without it the
// counters are tied to zero and no counter flops exist.
//
// There is no valid/ready handshake on this block: every output is a
// level that the pipeline registers consume at the same rising edge.
//
// The FSM state is observable on the `halted` output, which is decoded
// directly from the state register (and forced low while reset is high).

module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bub_cnt
);

  // Instruction codes that matter to hazard detection.
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  // Status codes; anything other than AOK is an exception.
  localparam logic [1:0] S_AOK    = 2'd0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] halt_stat_nxt;

  logic lu;
  logic ret;
  logic mp;
  logic exc;
  logic w_exc;

  // Hazard conditions from the current stage contents.
  always_comb begin
    lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
            (E_dstM != R_NONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp    = (E_icode == I_JXX) && !e_Cnd;
    w_exc = (W_stat != S_AOK);
    exc   = (m_stat != S_AOK) || w_exc;
  end

  // State register and latched halt status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      halt_stat <= S_AOK;
    end else begin
      state     <= state_nxt;
      halt_stat <= halt_stat_nxt;
    end
  end

  // Next state: a non-AOK status reaching W stops the machine for good;
  // only reset brings it back to RUN.
  always_comb begin
    state_nxt     = state;
    halt_stat_nxt = halt_stat;
    case (state)
      ST_RUN: begin
        if (w_exc) begin
          state_nxt     = ST_HALTED;
          halt_stat_nxt = W_stat;
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Pipeline register controls. Reset flushes the pipe with bubbles,
  // HALTED freezes it regardless of inputs, RUN applies the hazard logic.
  // A load/use stall on D wins over the bubble that ret would request.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    halted   = 1'b0;
    if (reset) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      halted   = 1'b1;
    end else begin
      F_stall  = lu | ret;
      D_stall  = lu;
      D_bubble = mp | (ret & ~lu);
      E_bubble = mp | lu;
      M_bubble = exc;
      W_stall  = w_exc;
      set_cc   = (E_icode == I_OPQ) & ~exc;
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bub_q;
  logic             cnt_run;

  // Counters only advance while the machine is running (reset is
  // handled first in the register block, so it never counts).
  assign cnt_run = (state == ST_RUN);

  // Saturating performance counters; they hold their value in HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      stall_q <= '0;
      bub_q   <= '0;
    end else if (cnt_run) begin
      if (!(&cyc_q)) begin
        cyc_q <= cyc_q + CNT_ONE;
      end
      if (F_stall && !(&stall_q)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if ((D_bubble || E_bubble) && !(&bub_q)) begin
        bub_q <= bub_q + CNT_ONE;
      end
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign bub_cnt   = bub_q;
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
  assign bub_cnt   = '0;
`endif

endmodule
